// File: rtl/uart_rx_vote_sampler.sv
// uart_rx_vote_sampler
// Oversampling bit sampler for the UART receiver. Optionally synchronises the
// raw rx line, collects an odd, run-time-selectable number of samples centred
// on mid-bit, and emits the majority-voted bit with a one-cycle valid strobe
// and a flag for windows whose samples disagreed.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_WAIT    | idle, waiting for edge_cnt to reach the window start (lo)
// ST_COLLECT | inside the window, accumulating ones until edge_cnt == hi
// ST_DONE    | vote taken; hold off until edge_cnt leaves hi or enable drops
module uart_rx_vote_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int MAX_SAMPLES = 7,
  parameter int SYNC_STAGES = 2,
  parameter int NS_W        = $clog2(MAX_SAMPLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [NS_W-1:0]       num_samples,
  output logic                  sampled_bit,
  output logic                  bit_valid,
  output logic                  noise_flag,
  output logic [NS_W-1:0]       ones_cnt
);

  // Window arithmetic is one bit wider than prescale so nothing wraps; it is
  // also widened to hold a vote count if NS_W happens to be the larger.
  localparam int CW = ((PRESCALE_W + 1) > NS_W) ? (PRESCALE_W + 1) : NS_W;
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_COLLECT,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic d_s;
  logic [NS_W-1:0] ds_ones;

  logic [NS_W-1:0] req_c;
  logic [CW-1:0]   req_half_c;
  logic [CW-1:0]   mid_c;
  logic [CW-1:0]   upper_c;
  logic [CW-1:0]   half_c;
  logic [CW-1:0]   n_c;
  logic [CW-1:0]   lo_c;
  logic [CW-1:0]   hi_c;

  logic [CW-1:0]   lo_q;
  logic [CW-1:0]   hi_q;
  logic [CW-1:0]   half_q;
  logic [CW-1:0]   n_q;

  logic [CW-1:0]   edge_w;
  logic [NS_W-1:0] ones_d;
  logic            load_win;
  logic            decide;
  logic [CW-1:0]   dec_half;
  logic [CW-1:0]   dec_n;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign d_s = data;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift the raw line through the synchroniser; idle-high on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= data;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign d_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign ds_ones = NS_W'(d_s);
  assign edge_w  = CW'(edge_cnt);

  // Effective vote size and window bounds from the live configuration inputs.
  always_comb begin
    req_c = num_samples;
    if (num_samples > NS_W'(MAX_SAMPLES)) begin
      req_c = NS_W'(MAX_SAMPLES);
    end
    if (req_c == '0) begin
      req_c = NS_W'(1);
    end else if (!req_c[0]) begin
      req_c = req_c - NS_W'(1);
    end
    req_half_c = (CW'(req_c) - ONE_C) >> 1;
    mid_c      = CW'(prescale) >> 1;
    // Room between mid-bit and the last edge of the bit; zero when prescale=0.
    upper_c    = (prescale == '0) ? '0 : (CW'(prescale) - ONE_C - mid_c);
    half_c     = req_half_c;
    if (mid_c < half_c) begin
      half_c = mid_c;
    end
    if (upper_c < half_c) begin
      half_c = upper_c;
    end
    n_c  = (half_c << 1) + ONE_C;
    lo_c = mid_c - half_c;
    hi_c = mid_c + half_c;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, running ones count and decision strobes.
  always_comb begin
    state_d  = state_q;
    ones_d   = ones_cnt;
    load_win = 1'b0;
    decide   = 1'b0;
    dec_half = half_q;
    dec_n    = n_q;
    case (state_q)
      ST_WAIT: begin
        if (enable && (edge_w == lo_c)) begin
          load_win = 1'b1;
          ones_d   = ds_ones;
          if (lo_c == hi_c) begin
            // Single-sample window: the first sample is also the vote.
            decide   = 1'b1;
            dec_half = half_c;
            dec_n    = n_c;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (!enable) begin
          state_d = ST_WAIT;
        end else if (edge_w == lo_q) begin
          // Bit counter restarted into the same window: begin counting afresh.
          ones_d = ds_ones;
        end else if (edge_w == hi_q) begin
          ones_d  = ones_cnt + ds_ones;
          decide  = 1'b1;
          state_d = ST_DONE;
        end else if ((edge_w > lo_q) && (edge_w < hi_q)) begin
          ones_d = ones_cnt + ds_ones;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        // Waiting here keeps a stalled edge_cnt from producing a second vote.
        if (!enable || (edge_w != hi_q)) begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // Window capture, ones counter and registered vote outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q        <= '0;
      hi_q        <= '0;
      half_q      <= '0;
      n_q         <= '0;
      ones_cnt    <= '0;
      sampled_bit <= 1'b1;
      noise_flag  <= 1'b0;
      bit_valid   <= 1'b0;
    end else begin
      bit_valid <= decide;
      ones_cnt  <= ones_d;
      if (load_win) begin
        lo_q   <= lo_c;
        hi_q   <= hi_c;
        half_q <= half_c;
        n_q    <= n_c;
      end
      if (decide) begin
        sampled_bit <= (CW'(ones_d) > dec_half);
        noise_flag  <= (ones_d != '0) && (CW'(ones_d) != dec_n);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// tb_uart_rx_vote_sampler
// Drives one unsynchronised and one two-stage-synchronised sampler with the
// same stimulus; expected votes are queued per instance and popped whenever
// bit_valid is seen.
module tb_uart_rx_vote_sampler;
  localparam int PW = 6;
  localparam int NW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b1;
  logic enable = 1'b0;
  logic [PW-1:0] edge_cnt = '0;
  logic [PW-1:0] prescale = 6'd8;
  logic [NW-1:0] num_samples = 3'd3;

  logic sb0, bv0, nf0;
  logic [NW-1:0] oc0;
  logic sb2, bv2, nf2;
  logic [NW-1:0] oc2;

  int checks = 0;
  int errors = 0;
  int vcnt0 = 0;
  int vcnt2 = 0;

  typedef struct {
    logic b;
    logic nz;
    logic [NW-1:0] ones;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];
  logic hist[$];
  logic cur_s0, cur_s2;
  logic last_bit0 = 1'b1;
  logic last_bit2 = 1'b1;

  uart_rx_vote_sampler #(.PRESCALE_W(PW), .MAX_SAMPLES(7), .SYNC_STAGES(0)) dut_s0 (
    .clk(clk), .rst(rst), .data(data), .enable(enable), .edge_cnt(edge_cnt),
    .prescale(prescale), .num_samples(num_samples), .sampled_bit(sb0),
    .bit_valid(bv0), .noise_flag(nf0), .ones_cnt(oc0)
  );

  uart_rx_vote_sampler #(.PRESCALE_W(PW), .MAX_SAMPLES(7), .SYNC_STAGES(2)) dut_s2 (
    .clk(clk), .rst(rst), .data(data), .enable(enable), .edge_cnt(edge_cnt),
    .prescale(prescale), .num_samples(num_samples), .sampled_bit(sb2),
    .bit_valid(bv2), .noise_flag(nf2), .ones_cnt(oc2)
  );

  always #5 clk = ~clk;

  // Scoreboard for the unsynchronised instance.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && bv0 === 1'b1) begin
      vcnt0++;
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL s0_unexpected_valid got bit=%b noise=%b ones=%0d, expected no bit_valid", sb0, nf0, oc0);
      end else begin
        x = q0.pop_front();
        if ({sb0, nf0, oc0} !== {x.b, x.nz, x.ones}) begin
          errors++;
          $display("FAIL s0_vote got bit=%b noise=%b ones=%0d, expected bit=%b noise=%b ones=%0d",
                   sb0, nf0, oc0, x.b, x.nz, x.ones);
        end
      end
    end
  end

  // Scoreboard for the synchronised instance.
  always @(negedge clk) begin
    exp_t x;
    if (!rst && bv2 === 1'b1) begin
      vcnt2++;
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL s2_unexpected_valid got bit=%b noise=%b ones=%0d, expected no bit_valid", sb2, nf2, oc2);
      end else begin
        x = q2.pop_front();
        if ({sb2, nf2, oc2} !== {x.b, x.nz, x.ones}) begin
          errors++;
          $display("FAIL s2_vote got bit=%b noise=%b ones=%0d, expected bit=%b noise=%b ones=%0d",
                   sb2, nf2, oc2, x.b, x.nz, x.ones);
        end
      end
    end
  end

  task automatic drive(input logic d, input logic en, input int e);
    data = d;
    enable = en;
    edge_cnt = e[PW-1:0];
    hist.push_back(d);
    cur_s0 = d;
    cur_s2 = hist[hist.size()-3];
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    hist.delete();
    hist.push_back(1'b1);
    hist.push_back(1'b1);
  endtask

  task automatic win(input int ps, input int ns, output int lo, output int hi,
                     output int half, output int n);
    int r, mid;
    r = (ns > 7) ? 7 : ns;
    if (r == 0) r = 1;
    else if (r % 2 == 0) r = r - 1;
    mid = ps / 2;
    half = (r - 1) / 2;
    if (mid < half) half = mid;
    if (ps >= 1 && (ps - 1 - mid) < half) half = ps - 1 - mid;
    if (ps == 0) half = 0;
    n = 2 * half + 1;
    lo = mid - half;
    hi = mid + half;
  endtask

  task automatic push_exp(input int which, input int ones, input int half, input int n);
    exp_t x;
    x.b = (ones > half);
    x.nz = (ones != 0) && (ones != n);
    x.ones = ones[NW-1:0];
    if (which == 0) begin
      q0.push_back(x);
      last_bit0 = x.b;
    end else begin
      q2.push_back(x);
      last_bit2 = x.b;
    end
  endtask

  task automatic run_bit(input int ps, input int ns, input logic [63:0] pat);
    int lo, hi, half, n, a0, a2;
    win(ps, ns, lo, hi, half, n);
    prescale = ps[PW-1:0];
    num_samples = ns[NW-1:0];
    a0 = 0;
    a2 = 0;
    for (int e = 0; e < ps; e++) begin
      drive(pat[e], 1'b1, e);
      if (e >= lo && e <= hi) begin
        a0 += int'(cur_s0);
        a2 += int'(cur_s2);
      end
      if (e == hi) begin
        push_exp(0, a0, half, n);
        push_exp(2, a2, half, n);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b0;
    clear_hist();
    checks++;
    if ({sb0, bv0, nf0, oc0} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_s0 got bit=%b valid=%b noise=%b ones=%0d, expected 1 0 0 0", sb0, bv0, nf0, oc0);
    end
    checks++;
    if ({sb2, bv2, nf2, oc2} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_s2 got bit=%b valid=%b noise=%b ones=%0d, expected 1 0 0 0", sb2, bv2, nf2, oc2);
    end
  endtask

  // prescale=8, 3 samples: window 3..5 sees 1,0,1 on the direct instance.
  task automatic test_basic();
    logic [7:0] pat;
    int a0, a2;
    pat = 8'b0010_1110;
    prescale = 6'd8;
    num_samples = 3'd3;
    a0 = 0;
    a2 = 0;
    for (int e = 0; e < 8; e++) begin
      drive(pat[e], 1'b1, e);
      if (e >= 3 && e <= 5) begin
        a0 += int'(cur_s0);
        a2 += int'(cur_s2);
      end
      if (e == 5) begin
        push_exp(0, a0, 1, 3);
        push_exp(2, a2, 1, 3);
      end
      checks++;
      if (bv0 !== (e == 5)) begin
        errors++;
        $display("FAIL basic_valid_timing edge=%0d got valid=%b, expected %b", e, bv0, (e == 5));
      end
      if (e == 5) begin
        checks++;
        if ({sb0, nf0, oc0} !== {1'b1, 1'b1, 3'd2}) begin
          errors++;
          $display("FAIL basic_vote got bit=%b noise=%b ones=%0d, expected 1 1 2", sb0, nf0, oc0);
        end
      end
    end
  endtask

  // prescale=16, 5 samples: window 6..10.
  task automatic test_wide();
    run_bit(16, 5, 64'h0000_0000_0000_0500);
    checks++;
    if ({sb0, nf0} !== 2'b01) begin
      errors++;
      $display("FAIL wide_mixed got bit=%b noise=%b, expected 0 1", sb0, nf0);
    end
    run_bit(16, 5, 64'h0000_0000_0000_FFFF);
    checks++;
    if ({sb0, nf0, oc0} !== {1'b1, 1'b0, 3'd5}) begin
      errors++;
      $display("FAIL wide_ones got bit=%b noise=%b ones=%0d, expected 1 0 5", sb0, nf0, oc0);
    end
  endtask

  task automatic test_clamp();
    int v0;
    // prescale=4 limits 7 requested samples to 3 (window 1..3).
    run_bit(4, 7, 64'h0000_0000_0000_000C);
    checks++;
    if ({sb0, nf0, oc0} !== {1'b1, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL clamp_ps4 got bit=%b noise=%b ones=%0d, expected 1 1 2", sb0, nf0, oc0);
    end
    // Even request of 4 votes over 3 samples.
    run_bit(8, 4, 64'h0000_0000_0000_004C);
    checks++;
    if ({sb0, nf0, oc0} !== {1'b0, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL clamp_even got bit=%b noise=%b ones=%0d, expected 0 1 1", sb0, nf0, oc0);
    end
    // Zero request: single sample at mid (edge 4), valid one clock later.
    prescale = 6'd8;
    num_samples = 3'd0;
    for (int e = 0; e < 8; e++) begin
      drive((e == 4) ? 1'b0 : 1'b1, 1'b1, e);
      if (e == 4) begin
        push_exp(0, int'(cur_s0), 0, 1);
        push_exp(2, int'(cur_s2), 0, 1);
      end
      checks++;
      if (bv0 !== (e == 4)) begin
        errors++;
        $display("FAIL single_valid_timing edge=%0d got valid=%b, expected %b", e, bv0, (e == 4));
      end
    end
    // prescale=0: edge 0 is the whole window; a stall there yields one vote.
    v0 = vcnt0;
    prescale = 6'd0;
    num_samples = 3'd3;
    drive(1'b1, 1'b1, 0);
    push_exp(0, int'(cur_s0), 0, 1);
    push_exp(2, int'(cur_s2), 0, 1);
    drive(1'b1, 1'b1, 0);
    drive(1'b1, 1'b1, 0);
    drive(1'b1, 1'b0, 0);
    checks++;
    if (vcnt0 - v0 != 1) begin
      errors++;
      $display("FAIL ps0_single_pulse got %0d valids, expected 1", vcnt0 - v0);
    end
  endtask

  task automatic test_abort_stall();
    int v0, v2, a0, a2;
    int es [10] = '{0, 1, 2, 3, 4, 3, 4, 5, 6, 7};
    run_bit(8, 3, 64'h0);
    checks++;
    if (sb0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_setup got bit=%b, expected 0", sb0);
    end
    v0 = vcnt0;
    v2 = vcnt2;
    // enable dropped at edge 4
    for (int e = 0; e < 4; e++) drive(1'b1, 1'b1, e);
    for (int e = 4; e < 8; e++) drive(1'b1, 1'b0, e);
    checks++;
    if ({vcnt0 - v0, vcnt2 - v2} !== {32'd0, 32'd0} || sb0 !== 1'b0 || sb2 !== last_bit2 || oc0 !== 3'd1) begin
      errors++;
      $display("FAIL abort_enable got valids=%0d/%0d bit=%b/%b ones=%0d, expected 0/0 0/%b 1",
               vcnt0 - v0, vcnt2 - v2, sb0, sb2, oc0, last_bit2);
    end
    // counter restart to edge 0 mid-window
    for (int e = 0; e < 5; e++) drive(1'b1, 1'b1, e);
    drive(1'b1, 1'b1, 0);
    checks++;
    if (vcnt0 - v0 != 0 || sb0 !== 1'b0 || oc0 !== 3'd2) begin
      errors++;
      $display("FAIL abort_restart got valids=%0d bit=%b ones=%0d, expected 0 0 2", vcnt0 - v0, sb0, oc0);
    end
    // edge_cnt stalls at hi=5 for three clocks
    v0 = vcnt0;
    for (int e = 1; e < 5; e++) drive(1'b1, 1'b1, e);
    drive(1'b1, 1'b1, 5);
    push_exp(0, 3, 1, 3);
    push_exp(2, 3, 1, 3);
    drive(1'b1, 1'b1, 5);
    drive(1'b1, 1'b1, 5);
    drive(1'b1, 1'b1, 6);
    drive(1'b1, 1'b1, 7);
    checks++;
    if (vcnt0 - v0 != 1) begin
      errors++;
      $display("FAIL stall_one_pulse got %0d valids, expected 1", vcnt0 - v0);
    end
    // edge_cnt goes back to lo inside the window: count restarts there
    a0 = 0;
    a2 = 0;
    for (int i = 0; i < 10; i++) begin
      drive((i >= 5) ? 1'b1 : 1'b0, 1'b1, es[i]);
      if (i >= 5 && i <= 7) begin
        a0 += int'(cur_s0);
        a2 += int'(cur_s2);
      end
      if (i == 7) begin
        push_exp(0, a0, 1, 3);
        push_exp(2, a2, 1, 3);
      end
    end
    checks++;
    if ({sb0, nf0, oc0} !== {1'b1, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL reload_window got bit=%b noise=%b ones=%0d, expected 1 0 3", sb0, nf0, oc0);
    end
  endtask

  // Data high only at edges 1,2: the synchronised instance sees it in the window.
  task automatic test_sync();
    run_bit(8, 3, 64'h0000_0000_0000_0006);
    checks++;
    if ({sb2, nf2, oc2} !== {1'b1, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL sync_delayed got bit=%b noise=%b ones=%0d, expected 1 1 2", sb2, nf2, oc2);
    end
    checks++;
    if ({sb0, nf0, oc0} !== {1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL sync_direct got bit=%b noise=%b ones=%0d, expected 0 0 0", sb0, nf0, oc0);
    end
  endtask

  task automatic test_async_reset();
    prescale = 6'd8;
    num_samples = 3'd3;
    for (int e = 0; e < 5; e++) drive(1'b1, 1'b1, e);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({sb0, bv0, nf0, oc0} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL async_rst_s0 got bit=%b valid=%b noise=%b ones=%0d, expected 1 0 0 0", sb0, bv0, nf0, oc0);
    end
    checks++;
    if ({sb2, bv2, nf2, oc2} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL async_rst_s2 got bit=%b valid=%b noise=%b ones=%0d, expected 1 0 0 0", sb2, bv2, nf2, oc2);
    end
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    clear_hist();
    run_bit(8, 3, 64'h0000_0000_0000_0028);
    checks++;
    if ({sb0, nf0, oc0} !== {1'b1, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL post_rst_vote got bit=%b noise=%b ones=%0d, expected 1 1 2", sb0, nf0, oc0);
    end
    drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_clamp();
    test_abort_stall();
    test_sync();
    test_async_reset();
    checks++;
    if (q0.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL pending_votes got %0d/%0d outstanding, expected 0/0", q0.size(), q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_vote_sampler.md
Name: uart_rx_vote_sampler

Overview:
Parametrised oversampling bit sampler for the UART receiver, the successor to the fixed 3-sample majority sampler. It optionally synchronises the raw rx line, then takes a run-time-selectable odd number of samples centred on mid-bit. It produces the majority-voted bit, a one-cycle valid strobe and a noise flag for disagreeing samples. It sits between the rx edge/bit counter and the rx FSM/deserializer.

Parameters:
PRESCALE_W, 6, width of prescale and edge_cnt
MAX_SAMPLES, 7, largest supported vote size; odd, 1..15
SYNC_STAGES, 2, flops on data before sampling; 0 means data is used directly
NS_W, $clog2(MAX_SAMPLES+1), width of num_samples

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
data  in  1  raw serial rx line
enable  in  1  sampling enabled by the rx FSM
edge_cnt  in  PRESCALE_W  oversample edge index within the current bit, 0..prescale-1
prescale  in  PRESCALE_W  oversampling ratio (edges per bit)
num_samples  in  NS_W  requested vote size
sampled_bit  out  1  voted bit value; holds between decisions
bit_valid  out  1  one-cycle pulse when sampled_bit is updated
noise_flag  out  1  set with each decision when samples were not unanimous
ones_cnt  out  NS_W  debug: ones counted in the current or last window

Behaviour:
- Reset (async, rst=1): sync chain=1, sampled_bit=1, bit_valid=0, noise_flag=0, ones_cnt=0, state=WAIT.
- Synchroniser: the sampled value d_s is data delayed by SYNC_STAGES clocks. edge_cnt is not delayed; the caller absorbs the latency.
- Effective vote size n_eff:
  - req = num_samples, clamped to MAX_SAMPLES.
  - Even req is reduced by 1; req=0 is treated as 1.
  - req_half = (req-1)/2.
  - mid = prescale>>1.
  - half = min(req_half, mid, prescale-1-mid) when prescale≥1.
  - n_eff = 2*half+1.
  - Window lo = mid-half, hi = mid+half.
  - All arithmetic is in PRESCALE_W+1 bits; there is no wrap.
- n_eff, lo and hi are registered when the window opens (WAIT→COLLECT). Changes to prescale or num_samples mid-window have no effect until the next window.
- States:
  - WAIT: when enable && edge_cnt==lo, capture d_s: ones_cnt = d_s. If lo==hi (n_eff=1), decide immediately and go to DONE; otherwise go to COLLECT.
  - COLLECT: each cycle with enable && edge_cnt in (lo,hi], ones_cnt += d_s. The vote is taken on the cycle edge_cnt==hi, including that sample, then state goes to DONE.
  - DONE: stay until edge_cnt != hi or enable=0, then go to WAIT. This guarantees one bit_valid per window even if edge_cnt stalls at hi.
- Decision (registered on the clock edge that samples edge_cnt==hi):
  - sampled_bit = (total_ones > half).
  - noise_flag = (total_ones != 0 && total_ones != n_eff).
  - bit_valid = 1 for exactly the next cycle.
  - Latency: valid is visible 1 clk after the edge_cnt==hi cycle.
- Abort conditions, each returning to WAIT with no bit_valid:
  - enable=0 in COLLECT.
  - edge_cnt outside [lo,hi] in COLLECT, e.g. a counter restart.
  - On abort, sampled_bit and noise_flag hold their previous values, and ones_cnt holds.
- edge_cnt == lo while in COLLECT (restart into the same window): treat as a fresh window start and reload ones_cnt = d_s.
- noise_flag holds until the next decision; it is not a sticky accumulate.
- prescale=0: mid=0, half=0, window is edge 0, n_eff=1.
- Reset asserted mid-window: immediate return to the reset values; no pulse.

Test Plan:
1. SYNC_STAGES=0, prescale=8, num_samples=3 → window 3..5; d_s=1,0,1 at edges 3,4,5 → the cycle after edge 5: bit_valid=1 for 1 clk, sampled_bit=1, noise_flag=1, ones_cnt=2.
2. prescale=16, num_samples=5 → window 6..10; data 0,0,1,0,1 → sampled_bit=0, noise_flag=1. Repeat with all ones → sampled_bit=1, noise_flag=0.
3. Clamping:
   - prescale=4, num_samples=7 → half=min(3,2,1)=1, window 1..3, n_eff=3.
   - num_samples=4 → n_eff=3.
   - num_samples=0 → single sample at edge mid; bit_valid follows edge mid by 1 clk.
4. Aborts and stalls:
   - prescale=8, n=3, sampled_bit=0 from the previous bit; drop enable at edge 4 → no bit_valid, sampled_bit stays 0.
   - Edge_cnt held at 5 for 3 clks → exactly one bit_valid.
5. SYNC_STAGES=2: data toggles 2 clks before edge_cnt reaches the window → samples reflect the data value from 2 clks earlier. Verify vote against a delayed-data model.
6. Assert rst asynchronously (between clock edges) during COLLECT → outputs return immediately to sampled_bit=1, bit_valid=0, noise_flag=0, ones_cnt=0. The next full window after release decides correctly.
